// File: rtl/fifo_serializer.sv
// rtl/fifo_serializer.sv - FWFT FIFO tag/data unpacker feeding per-lane MSB-first serial shifters
module fifo_serializer #(
    parameter int CHANNELS = 8,
    parameter int WORD_W   = 16
) (
    input  logic                ext_clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   fifo_dout,
    input  logic                fifo_empty,
    output logic                fifo_ren,
    output logic [CHANNELS-1:0] serial_out,
    output logic                frame_sync,
    output logic                underrun,
    output logic                tag_error,
    output logic [15:0]         frames_sent
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BC_W = $clog2(WORD_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_TAG,
        S_DATA,
        S_FULL
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [BC_W-1:0]     r_bit_cnt;
    logic [WORD_W-1:0]   r_shreg   [CHANNELS];
    logic [WORD_W-1:0]   r_staging [CHANNELS];
    logic [CHANNELS-1:0] r_mask;
    logic [CHANNELS-1:0] w_mask_next;
    logic [CH_W-1:0]     r_ch;
    logic                r_underrun;
    logic                r_tag_error;
    logic [15:0]         r_frames_sent;

    logic w_boundary;
    logic w_load;
    logic w_tag_ok;

    // Last bit of the frame; the load decision uses the mask as registered, not this cycle's pop
    assign w_boundary = (r_bit_cnt == LAST_BIT);
    assign w_load     = w_boundary && (&r_mask);
    // A tag carries only a channel index in its low nibble; anything else is malformed
    assign w_tag_ok   = (fifo_dout[WORD_W-1:4] == '0) && ({1'b0, fifo_dout[3:0]} < 5'(CHANNELS));

    assign frame_sync  = (r_bit_cnt == '0);
    assign underrun    = r_underrun;
    assign tag_error   = r_tag_error;
    assign frames_sent = r_frames_sent;

    // Lane outputs are the MSB of each shift register
    always_comb begin
        serial_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            serial_out[c] = r_shreg[c][WORD_W-1];
        end
    end

    // Pop strobe, next-state and next-mask; a successful load clears the mask before this cycle's pop lands
    always_comb begin
        fifo_ren     = !rst && !fifo_empty && (r_state != S_FULL);
        w_mask_next  = w_load ? '0 : r_mask;
        w_state_next = w_load ? S_TAG : r_state;
        if (fifo_ren) begin
            case (r_state)
                S_TAG:   w_state_next = w_tag_ok ? S_DATA : S_TAG;
                S_DATA: begin
                    w_mask_next[r_ch] = 1'b1;
                    w_state_next      = (&w_mask_next) ? S_FULL : S_TAG;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // State register
    always_ff @(posedge ext_clk) begin
        if (rst) begin
            r_state <= S_TAG;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bit counter, tag capture, staging mask and sticky status
    always_ff @(posedge ext_clk) begin
        if (rst) begin
            r_bit_cnt     <= '0;
            r_mask        <= '0;
            r_ch          <= '0;
            r_underrun    <= 1'b0;
            r_tag_error   <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + 1'b1;
            r_mask    <= w_mask_next;
            if (fifo_ren && (r_state == S_TAG)) begin
                if (w_tag_ok) begin
                    r_ch <= fifo_dout[CH_W-1:0];
                end else begin
                    r_tag_error <= 1'b1;
                end
            end
            if (w_boundary) begin
                if (w_load) begin
                    r_frames_sent <= r_frames_sent + 16'd1;
                end else begin
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    // Data words land in the staging slot of the most recently accepted tag
    always_ff @(posedge ext_clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_staging[c] <= '0;
            end
        end else if (fifo_ren && (r_state == S_DATA)) begin
            r_staging[r_ch] <= fifo_dout;
        end
    end

    // Shift every lane each bit; at the boundary load the staged set or send a zero frame
    always_ff @(posedge ext_clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst) begin
                r_shreg[c] <= '0;
            end else if (w_boundary) begin
                r_shreg[c] <= w_load ? r_staging[c] : '0;
            end else begin
                r_shreg[c] <= r_shreg[c] << 1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb/tb_fifo_serializer.sv - directed self-checking bench for fifo_serializer
module tb_fifo_serializer;

    typedef logic [15:0] frame_t [8];

    typedef struct {
        logic        rst_before;
        logic [15:0] word;
        logic        exp_ren;
        logic        exp_err;
    } vec_t;

    logic        ext_clk = 1'b0;
    logic        rst;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [7:0]  serial_out;
    logic        frame_sync;
    logic        underrun;
    logic        tag_error;
    logic [15:0] frames_sent;

    logic [15:0] q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    vec_t        vecs [10];
    frame_t      zf;
    frame_t      f;

    fifo_serializer #(.CHANNELS(8), .WORD_W(16)) dut (
        .ext_clk     (ext_clk),
        .rst         (rst),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_ren    (fifo_ren),
        .serial_out  (serial_out),
        .frame_sync  (frame_sync),
        .underrun    (underrun),
        .tag_error   (tag_error),
        .frames_sent (frames_sent)
    );

    always #5 ext_clk = ~ext_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_dout  = fifo_empty ? 16'h0000 : q[0];
    endtask

    task automatic push(input logic [15:0] w);
        q.push_back(w);
        refresh();
    endtask

    // One clock: the FIFO model pops exactly when the strobe was high before the edge
    task automatic step();
        logic        ren;
        logic [15:0] tmp;
        #1;
        ren = fifo_ren;
        @(posedge ext_clk);
        if (ren && q.size() > 0) tmp = q.pop_front();
        #1;
        refresh();
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        refresh();
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        #1;
    endtask

    task automatic push_pair(input int ch, input logic [15:0] d);
        push(16'(ch));
        push(d);
    endtask

    // Checks 16 bits of every lane MSB-first starting at the current frame_sync cycle
    task automatic check_frame(input string name, input frame_t exp);
        logic [7:0] ev;
        for (int i = 0; i < 16; i++) begin
            for (int ch = 0; ch < 8; ch++) ev[ch] = exp[ch][15-i];
            chk({name, " serial"}, 32'(serial_out), 32'(ev));
            chk({name, " sync"}, 32'(frame_sync), 32'(i == 0));
            step();
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0003, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'h0007, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h0008, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 16'h0010, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 16'h0007, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 16'h00F0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 16'h0100, 1'b1, 1'b1};
        zf = '{default: 16'h0000};
        rst = 1'b1;
        refresh();

        // Empty FIFO after reset: zero lanes, sync every 16, underrun after first boundary
        do_reset();
        chk("empty ren", 32'(fifo_ren), 32'd0);
        for (int k = 0; k < 48; k++) begin
            chk("idle serial", 32'(serial_out), 32'd0);
            chk("idle sync", 32'(frame_sync), 32'(k % 16 == 0));
            chk("idle underrun", 32'(underrun), 32'(k >= 16));
            step();
        end
        chk("idle frames", 32'(frames_sent), 32'd0);

        // Tag parsing table: one word per cycle, sticky tag_error
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst_before) do_reset();
            push(vecs[i].word);
            #1;
            chk("vec ren", 32'(fifo_ren), 32'(vecs[i].exp_ren));
            step();
            chk("vec tag_error", 32'(tag_error), 32'(vecs[i].exp_err));
        end

        // Preloaded full set: last data pops in the boundary cycle, so it loads one frame late
        do_reset();
        for (int ch = 0; ch < 8; ch++) push_pair(ch, 16'hA500 + 16'(ch));
        for (int k = 0; k < 15; k++) step();
        chk("pre last pop ren", 32'(fifo_ren), 32'd1);
        chk("pre underrun0", 32'(underrun), 32'd0);
        step();
        chk("pre underrun1", 32'(underrun), 32'd1);
        chk("pre frames0", 32'(frames_sent), 32'd0);
        check_frame("pre zero frame", zf);
        chk("pre frames1", 32'(frames_sent), 32'd1);
        for (int ch = 0; ch < 8; ch++) f[ch] = 16'hA500 + 16'(ch);
        check_frame("pre A5 frame", f);

        // Malformed tag first, then valid pairs; no pops while full
        do_reset();
        push(16'h0010);
        for (int ch = 0; ch < 8; ch++) push_pair(ch, 16'hC300 | 16'(ch));
        step();
        chk("bad tag flagged", 32'(tag_error), 32'd1);
        for (int k = 1; k < 17; k++) step();
        push(16'h0002);
        for (int k = 17; k < 32; k++) begin
            chk("full no pop", 32'(fifo_ren), 32'd0);
            step();
        end
        chk("after load ren", 32'(fifo_ren), 32'd1);
        chk("bad tag frames", 32'(frames_sent), 32'd1);
        for (int ch = 0; ch < 8; ch++) f[ch] = 16'hC300 | 16'(ch);
        check_frame("bad tag frame", f);

        // Reset mid-frame with partial staging; only post-reset data may appear
        do_reset();
        push(16'h0010);
        for (int ch = 0; ch < 4; ch++) push_pair(ch, 16'hDEAD);
        for (int k = 0; k < 20; k++) step();
        chk("prerst tag_error", 32'(tag_error), 32'd1);
        chk("prerst underrun", 32'(underrun), 32'd1);
        rst = 1'b1;
        for (int ch = 4; ch < 8; ch++) push_pair(ch, 16'h5A00 + 16'(ch));
        #1;
        chk("rst ren", 32'(fifo_ren), 32'd0);
        step();
        step();
        chk("rst ren held", 32'(fifo_ren), 32'd0);
        rst = 1'b0;
        cyc = 0;
        #1;
        chk("rst tag_error", 32'(tag_error), 32'd0);
        chk("rst underrun", 32'(underrun), 32'd0);
        chk("rst frames", 32'(frames_sent), 32'd0);
        chk("rst serial", 32'(serial_out), 32'd0);
        check_frame("rst half a", zf);
        check_frame("rst half b", zf);
        chk("rst no load", 32'(frames_sent), 32'd0);
        for (int ch = 0; ch < 4; ch++) push_pair(ch, 16'h1100 + 16'(ch));
        check_frame("rst completing", zf);
        chk("rst frames1", 32'(frames_sent), 32'd1);
        for (int ch = 0; ch < 8; ch++) f[ch] = (ch < 4) ? 16'h1100 + 16'(ch) : 16'h5A00 + 16'(ch);
        check_frame("rst post data", f);

        // Three sets streamed back to back
        do_reset();
        for (int s = 0; s < 3; s++)
            for (int ch = 0; ch < 8; ch++) push_pair(ch, (16'(s + 1) << 12) | 16'h0080 | 16'(ch));
        for (int k = 0; k < 16; k++) step();
        for (int k = 16; k < 32; k++) begin
            chk("stream full no pop", 32'(fifo_ren), 32'd0);
            step();
        end
        for (int s = 0; s < 3; s++) begin
            chk("stream frames", 32'(frames_sent), 32'(s + 1));
            for (int ch = 0; ch < 8; ch++) f[ch] = (16'(s + 1) << 12) | 16'h0080 | 16'(ch);
            check_frame("stream set", f);
            if (s < 2) begin
                chk("stream wait ren", 32'(fifo_ren), 32'd0);
                check_frame("stream gap", zf);
            end
        end
        chk("stream frames final", 32'(frames_sent), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
